// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared binary32 constants, field struct and divider FSM states
package fp_pkg;

    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORMALISE,
        DONE
    } fp_div_state_e;

endpackage

// File: rtl/fp_special_classifier.sv
// rtl/fp_special_classifier.sv - unpacks divider operands and flags zero/inf/NaN shortcuts
// FP_DIVIDER_SPECIALS_EN adds exponent-255 (inf/NaN) classification
module fp_special_classifier
    import fp_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        sign,
    output logic [23:0] sig_a,
    output logic [23:0] sig_b,
    output logic        is_special,
    output logic [31:0] special_result
);

    fp32_t fa;
    fp32_t fb;
    logic  a_zero;
    logic  b_zero;
    logic [31:0] inf_result;
    logic [31:0] zero_result;

    assign fa          = fp32_t'(a);
    assign fb          = fp32_t'(b);
    assign sign        = fa.sign ^ fb.sign;
    assign sig_a       = {1'b1, fa.frac};
    assign sig_b       = {1'b1, fb.frac};
    assign a_zero      = (fa.exp == 8'd0);
    assign b_zero      = (fb.exp == 8'd0);
    assign inf_result  = {sign, 8'(FP_EXP_MAX), 23'd0};
    assign zero_result = {sign, 31'd0};

`ifdef FP_DIVIDER_SPECIALS_EN
    logic a_max;
    logic b_max;
    logic a_nan;
    logic b_nan;

    assign a_max = (fa.exp == 8'(FP_EXP_MAX));
    assign b_max = (fb.exp == 8'(FP_EXP_MAX));
    assign a_nan = a_max && (fa.frac != 23'd0);
    assign b_nan = b_max && (fb.frac != 23'd0);

    always_comb begin
        is_special     = 1'b1;
        special_result = FP_QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_max && b_max)) begin
            special_result = FP_QNAN;
        end else if (b_zero) begin
            special_result = inf_result;
        end else if (a_zero) begin
            special_result = zero_result;
        end else if (a_max) begin
            special_result = inf_result;
        end else if (b_max) begin
            special_result = zero_result;
        end else begin
            is_special     = 1'b0;
            special_result = '0;
        end
    end
`else
    // A zero divisor wins over a zero dividend, so 0/0 yields infinity here.
    always_comb begin
        is_special     = 1'b0;
        special_result = '0;
        if (b_zero) begin
            is_special     = 1'b1;
            special_result = inf_result;
        end else if (a_zero) begin
            is_special     = 1'b1;
            special_result = zero_result;
        end
    end
`endif

endmodule

// File: rtl/floating_point_divider.sv
// rtl/floating_point_divider.sv - iterative binary32 divider, restoring, truncating, FTZ
// FP_DIVIDER_SPECIALS_EN (in fp_special_classifier) enables inf/NaN handling
module floating_point_divider
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    fp_div_state_e state;
    fp_div_state_e next_state;

    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        mb_q;
    logic [24:0]        rem_q;
    logic [24:0]        quo_q;
    logic [4:0]         cnt_q;

    logic               op_sign;
    logic [23:0]        op_sig_a;
    logic [23:0]        op_sig_b;
    logic               is_special;
    logic [31:0]        special_result;
    logic               accept;

    logic               q_bit;
    logic [23:0]        rem_sub;
    logic signed [9:0]  exp_norm;
    logic [22:0]        frac_norm;
    logic [31:0]        norm_result;

    fp_special_classifier u_special (
        .a              (a),
        .b              (b),
        .sign           (op_sign),
        .sig_a          (op_sig_a),
        .sig_b          (op_sig_b),
        .is_special     (is_special),
        .special_result (special_result)
    );

    assign accept = in_valid && in_ready;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (accept) next_state = is_special ? DONE : DIVIDE;
            DIVIDE:    if (cnt_q == 5'd0) next_state = NORMALISE;
            NORMALISE: next_state = DONE;
            DONE:      if (out_ready) next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // The remainder stays below the divisor after each step, so 24 bits hold it.
    always_comb begin
        q_bit   = (rem_q >= {1'b0, mb_q});
        rem_sub = q_bit ? 24'(rem_q - {1'b0, mb_q}) : rem_q[23:0];
        if (quo_q[24]) begin
            frac_norm = quo_q[23:1];
            exp_norm  = exp_q;
        end else begin
            frac_norm = quo_q[22:0];
            exp_norm  = exp_q - 10'sd1;
        end
        if (exp_norm >= $signed(10'(FP_EXP_MAX))) begin
            norm_result = {sign_q, 8'(FP_EXP_MAX), 23'd0};
        end else if (exp_norm <= 10'sd0) begin
            norm_result = {sign_q, 31'd0};
        end else begin
            norm_result = {sign_q, exp_norm[7:0], frac_norm};
        end
    end

    // Quotient bits shift in MSB-first, landing q[24] at the top after 25 steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mb_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q <= op_sign;
                        exp_q  <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]})
                                  + $signed(10'(FP_BIAS));
                        mb_q   <= op_sig_b;
                        rem_q  <= {1'b0, op_sig_a};
                        quo_q  <= '0;
                        cnt_q  <= 5'd24;
                        if (is_special) out <= special_result;
                    end
                end
                DIVIDE: begin
                    rem_q <= {rem_sub, 1'b0};
                    quo_q <= {quo_q[23:0], q_bit};
                    cnt_q <= cnt_q - 5'd1;
                end
                NORMALISE: out <= norm_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_floating_point_divider.sv
// tb/tb_floating_point_divider.sv - directed vectors plus arithmetic reference model for floating_point_divider
module tb_floating_point_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_out = '0;
    bit          model_armed = 1'b0;

    floating_point_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Quotient as an exact integer ratio scaled by 2^24, then truncated into binary32.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
        logic        s;
        int          ex, ey, e;
        longint      mx, my, q;
        logic [63:0] qb;
        logic [22:0] fr;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
`ifdef FP_DIVIDER_SPECIALS_EN
        begin
            bit xn, yn, xi, yi;
            xn = (ex == 255) && (x[22:0] != 0);
            yn = (ey == 255) && (y[22:0] != 0);
            xi = (ex == 255) && (x[22:0] == 0);
            yi = (ey == 255) && (y[22:0] == 0);
            if (xn || yn || (ex == 0 && ey == 0) || (xi && yi)) return 32'h7FC00000;
            if (ey == 0) return {s, 8'hFF, 23'd0};
            if (ex == 0) return {s, 31'd0};
            if (xi) return {s, 8'hFF, 23'd0};
            if (yi) return {s, 31'd0};
        end
`else
        if (ey == 0) return {s, 8'hFF, 23'd0};
        if (ex == 0) return {s, 31'd0};
`endif
        mx = longint'(x[22:0]) + 64'd8388608;
        my = longint'(y[22:0]) + 64'd8388608;
        q  = (mx * 64'd16777216) / my;
        qb = q;
        e  = ex - ey + 127;
        if (q >= 64'd16777216) fr = qb[23:1];
        else begin
            fr = qb[22:0];
            e  = e - 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), fr};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (model_armed) check("out_vs_model", out, model_out);
            else check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end
    end

    // Called at a negedge; leaves the bench at a negedge with the DUT idle.
    task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                          input bit has_lit, input logic [31:0] lit, input int exp_lat,
                          input int hold);
        int          lat;
        int          w;
        logic [31:0] first;
        if (has_lit) check({name, "_model"}, model(x, y), lit);
        w = 0;
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        a = x;
        b = y;
        in_valid = 1'b1;
        model_out = model(x, y);
        model_armed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (has_lit) check({name, "_out"}, out, lit);
        first = out;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_out"}, out, first);
            check({name, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            check({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
        check({name, "_drain_in_ready"}, {31'd0, in_ready}, 32'd1);
        model_armed = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_in_ready", {31'd0, in_ready}, 32'd1);

        run_op("six_by_two",  32'h40C00000, 32'h40000000, 1, 32'h40400000, 27, 0);
        run_op("one_third",   32'h3F800000, 32'h40400000, 1, 32'h3EAAAAAA, 27, 0);
        run_op("neg_eight",   32'hC1000000, 32'h3F000000, 1, 32'hC1800000, 27, 0);
        run_op("div_zero",    32'h3F800000, 32'h00000000, 1, 32'h7F800000, 1, 0);
        run_op("neg_zero",    32'h80000000, 32'h40000000, 1, 32'h80000000, 1, 0);
        run_op("overflow",    32'h7F000000, 32'h00800000, 1, 32'h7F800000, 27, 0);
        run_op("underflow",   32'h00800000, 32'h7F000000, 1, 32'h00000000, 27, 0);
`ifdef FP_DIVIDER_SPECIALS_EN
        run_op("nan_in",      32'h7FC00000, 32'h3F800000, 1, 32'h7FC00000, 1, 0);
        run_op("zero_zero",   32'h00000000, 32'h00000000, 1, 32'h7FC00000, 1, 0);
`else
        run_op("exp255_in",   32'h7FC00000, 32'h3F800000, 1, 32'h7F800000, 27, 0);
        run_op("zero_zero",   32'h00000000, 32'h00000000, 1, 32'h7F800000, 1, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            logic [31:0] rx, ry;
            rx = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            ry = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
            run_op("random", rx, ry, 0, 32'd0, 27, 0);
        end

        run_op("backpressure", 32'h40C00000, 32'h40000000, 1, 32'h40400000, 27, 10);

        // Abort mid-division: reset lands during the 12th DIVIDE cycle.
        a = 32'h3F800000;
        b = 32'h40400000;
        in_valid = 1'b1;
        model_out = model(a, b);
        model_armed = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        model_armed = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_out", out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rel_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_rel_out_valid", {31'd0, out_valid}, 32'd0);

        run_op("after_abort", 32'h40C00000, 32'h40000000, 1, 32'h40400000, 27, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
